// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX boundary of the RV32 five-stage pipeline.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Field order matches the decoder's control bundle, MSB first.
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       halt;
    logic       jump;
    logic       jump_reg;
  } ctrl_t;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_HALT   = 7'h7F;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_STOP
  } state_t;

  // Cycles spent in DRAIN beyond the first, so the halt retires past WB.
  localparam logic [1:0] DRAIN_LAST = 2'd3;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoded-instruction bundle entering the ID/EX register and the registered EX-side copy.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic              id_use_rs1;
  logic              id_use_rs2;

  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;

  modport master (
    output id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_use_rs1, id_use_rs2,
    output ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7
  );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational load-use detection and the stall request sent back to PC and IF/ID.
module hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_flush,
  input  logic              run,
  output logic              load_use,
  output logic              stall
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  assign stall = (run & load_use & ~ex_flush) | ~run;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, branch flush and HALT drain-to-stop sequencing.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus,
  input  logic          ex_flush,
  output logic          stall,
  output logic          halted
);

  state_t     state;
  state_t     state_next;
  logic [1:0] drain_cnt;
  logic       run;
  logic       load_use;
  logic       capture;

  assign run     = (state == ST_RUN);
  assign capture = run & ~ex_flush & ~load_use;

  hazard_unit u_hazard (
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (bus.ex_ctrl.mem_read),
    .ex_rd       (bus.ex_rd),
    .id_valid    (bus.id_valid),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .ex_flush    (ex_flush),
    .run         (run),
    .load_use    (load_use),
    .stall       (stall)
  );

  // A halt only counts once it actually lands in EX; a flushed halt is simply dropped.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:   if (capture && bus.id_valid && bus.id_ctrl.halt) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = ST_STOP;
      ST_STOP:  state_next = ST_STOP;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      halted    <= halted | (state_next == ST_STOP);
    end
  end

  // Bubbles clear only ctrl/valid; datapath fields keep stale values nobody will consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_ctrl   <= CTRL_NOP;
      bus.ex_pc     <= '0;
      bus.ex_rd1    <= '0;
      bus.ex_rd2    <= '0;
      bus.ex_imm    <= '0;
      bus.ex_rs1    <= '0;
      bus.ex_rs2    <= '0;
      bus.ex_rd     <= '0;
      bus.ex_funct3 <= '0;
      bus.ex_funct7 <= '0;
    end else if (!capture) begin
      bus.ex_valid <= 1'b0;
      bus.ex_ctrl  <= CTRL_NOP;
    end else begin
      bus.ex_valid  <= bus.id_valid;
      bus.ex_ctrl   <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
      bus.ex_pc     <= bus.id_pc;
      bus.ex_rd1    <= bus.id_rd1;
      bus.ex_rd2    <= bus.id_rd2;
      bus.ex_imm    <= bus.id_imm;
      bus.ex_rs1    <= bus.id_rs1;
      bus.ex_rs2    <= bus.id_rs2;
      bus.ex_rd     <= bus.id_rd;
      bus.ex_funct3 <= bus.id_funct3;
      bus.ex_funct7 <= bus.id_funct7;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each step drives one ID instruction and scores the EX result one cycle later.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ex_flush;
  logic stall;
  logic halted;

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ex_flush (ex_flush),
    .stall    (stall),
    .halted   (halted)
  );

  // Control encodings {alu_src,mem_to_reg,reg_write,mem_read,mem_write,alu_op[1:0],branch,halt,jump,jump_reg}
  localparam logic [10:0] C_NONE = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] C_ADDI = 11'b1_0_1_0_0_10_0_0_0_0;
  localparam logic [10:0] C_LW   = 11'b1_1_1_1_0_00_0_0_0_0;
  localparam logic [10:0] C_ADD  = 11'b0_0_1_0_0_10_0_0_0_0;
  localparam logic [10:0] C_HALT = 11'b0_0_0_0_0_00_0_1_0_0;

  typedef struct {
    logic        valid;
    logic [10:0] ctrl;
    logic        halted;
    logic        chk_data;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_ctr = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check_val("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
    check_val("ex_ctrl", 32'(bus.ex_ctrl), 32'(e.ctrl));
    check_val("halted", 32'(halted), 32'(e.halted));
    if (e.chk_data) begin
      check_val("ex_pc", bus.ex_pc, e.pc);
      check_val("ex_rd1", bus.ex_rd1, e.rd1);
      check_val("ex_rd2", bus.ex_rd2, e.rd2);
      check_val("ex_imm", bus.ex_imm, e.imm);
      check_val("ex_rs1", 32'(bus.ex_rs1), 32'(e.rs1));
      check_val("ex_rs2", 32'(bus.ex_rs2), 32'(e.rs2));
      check_val("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      check_val("ex_funct3", 32'(bus.ex_funct3), 32'(e.f3));
      check_val("ex_funct7", 32'(bus.ex_funct7), 32'(e.f7));
    end
  endtask

  task automatic drive_id(input logic v, input logic [10:0] c, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                          input logic u1, input logic u2, input logic flush);
    pc_ctr          = pc_ctr + 32'd4;
    bus.id_valid    = v;
    bus.id_ctrl     = ctrl_t'(c);
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_imm      = imm;
    bus.id_use_rs1  = u1;
    bus.id_use_rs2  = u2;
    bus.id_pc       = pc_ctr;
    bus.id_rd1      = imm ^ 32'hA5A5_0000;
    bus.id_rd2      = pc_ctr + 32'h0000_1000;
    bus.id_funct3   = rd[2:0];
    bus.id_funct7   = {2'b01, rs2};
    ex_flush        = flush;
  endtask

  // One pipeline cycle: drive ID, check the combinational stall, push the EX expectation, clock, score.
  task automatic apply_stimulus(input logic v, input logic [10:0] c, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                                input logic u1, input logic u2, input logic flush,
                                input logic exp_stall, input logic exp_valid,
                                input logic [10:0] exp_ctrl, input logic exp_halted);
    exp_t e;
    @(negedge clk);
    drive_id(v, c, rs1, rs2, rd, imm, u1, u2, flush);
    #1;
    check_val("stall", 32'(stall), 32'(exp_stall));
    e.valid    = exp_valid;
    e.ctrl     = exp_ctrl;
    e.halted   = exp_halted;
    e.chk_data = exp_valid;
    e.pc       = pc_ctr;
    e.rd1      = imm ^ 32'hA5A5_0000;
    e.rd2      = pc_ctr + 32'h0000_1000;
    e.imm      = imm;
    e.rs1      = rs1;
    e.rs2      = rs2;
    e.rd       = rd;
    e.f3       = rd[2:0];
    e.f7       = {2'b01, rs2};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    drive_id(1'b0, C_NONE, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check_val("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    check_val("rst_ex_pc", bus.ex_pc, 32'd0);
    check_val("rst_ex_imm", bus.ex_imm, 32'd0);
    check_val("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ex_flush = 1'b0;
    drive_id(1'b0, C_NONE, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_reset(2);

    // addi x1,x0,5
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1, 0, 0,   0, 1, C_ADDI, 0);
    // lw x2,0(x1) then dependent add x3,x2,x1: one stall, one bubble, then the add
    apply_stimulus(1, C_LW,   5'd1, 5'd0, 5'd2, 32'd0, 1, 0, 0,   0, 1, C_LW,   0);
    apply_stimulus(1, C_ADD,  5'd2, 5'd1, 5'd3, 32'd0, 1, 1, 0,   1, 0, C_NONE, 0);
    apply_stimulus(1, C_ADD,  5'd2, 5'd1, 5'd3, 32'd0, 1, 1, 0,   0, 1, C_ADD,  0);
    // lw x0 then add x3,x0,x1: x0 never stalls
    apply_stimulus(1, C_LW,   5'd1, 5'd0, 5'd0, 32'd8, 1, 0, 0,   0, 1, C_LW,   0);
    apply_stimulus(1, C_ADD,  5'd0, 5'd1, 5'd3, 32'd0, 1, 1, 0,   0, 1, C_ADD,  0);
    // lw x2 then dependent add with flush in the same cycle
    apply_stimulus(1, C_LW,   5'd1, 5'd0, 5'd2, 32'd4, 1, 0, 0,   0, 1, C_LW,   0);
    apply_stimulus(1, C_ADD,  5'd2, 5'd1, 5'd3, 32'd0, 1, 1, 1,   0, 0, C_NONE, 0);
    apply_stimulus(1, C_ADD,  5'd2, 5'd1, 5'd3, 32'd0, 1, 1, 0,   0, 1, C_ADD,  0);
    // invalid ID slot: ctrl must be forced to NOP
    apply_stimulus(0, C_ADDI, 5'd0, 5'd0, 5'd4, 32'd9, 1, 0, 0,   0, 0, C_NONE, 0);
    // halt under flush is discarded; following addi proceeds normally
    apply_stimulus(1, C_HALT, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 1,   0, 0, C_NONE, 0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd7, 1, 0, 0,   0, 1, C_ADDI, 0);
    // halt captured, then drain (flush mid-drain ignored) and sticky stop
    apply_stimulus(1, C_HALT, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0,   0, 1, C_HALT, 0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd1, 1, 0, 0,   1, 0, C_NONE, 0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd2, 1, 0, 1,   1, 0, C_NONE, 0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd3, 1, 0, 0,   1, 0, C_NONE, 0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd4, 1, 0, 0,   1, 0, C_NONE, 1);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1, 0, 0,   1, 0, C_NONE, 1);

    // reset asserted in the middle of DRAIN
    do_reset(1);
    apply_stimulus(1, C_HALT, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0,   0, 1, C_HALT, 0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd6, 1, 0, 0,   1, 0, C_NONE, 0);
    @(negedge clk);
    reset = 1'b1;
    drive_id(1'b1, C_ADDI, 5'd0, 5'd0, 5'd1, 32'd6, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_val("drain_rst_valid", 32'(bus.ex_valid), 32'd0);
    check_val("drain_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("drain_rst_stall", 32'(stall), 32'd0);
    apply_stimulus(1, C_ADDI, 5'd0, 5'd0, 5'd5, 32'd11, 1, 0, 0,  0, 1, C_ADDI, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
